// File: rtl/keccak_pkg.sv
// Shared Keccak constants and the squeeze-stage state encoding.
package keccak_pkg;
    localparam int STATE_W             = 1600;
    localparam int LANE_W              = 64;
    localparam int NUM_LANES           = 25;
    localparam int LANE_IDX_W          = 5;
    localparam int SHAKE128_RATE_LANES = 21;
    localparam int SHAKE256_RATE_LANES = 17;

    typedef enum logic [1:0] {
        SQ_IDLE,
        SQ_WAIT_ST,
        SQ_EMIT,
        SQ_PERM
    } sq_state_e;
endpackage

// File: rtl/keccak_lane_mux.sv
// Combinational 25:1 lane select from a 1600-bit Keccak state (lane i = x+5y).
module keccak_lane_mux
    import keccak_pkg::*;
(
    input  logic [STATE_W-1:0]    i_state,
    input  logic [LANE_IDX_W-1:0] i_idx,
    output logic [LANE_W-1:0]     o_lane
);
    // Out-of-range indices (25..31) read as zero.
    always_comb begin
        o_lane = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (i_idx == LANE_IDX_W'(i)) o_lane = i_state[i*LANE_W +: LANE_W];
        end
    end
endmodule

// File: rtl/keccak_squeeze.sv
// Keccak sponge squeeze stage: streams rate lanes as 64-bit words and requests
// further permutations. Define KECCAK_SQUEEZE_ABORT_EN to add the abort input.
module keccak_squeeze
    import keccak_pkg::*;
#(
    parameter int RATE_LANES = SHAKE128_RATE_LANES,
    parameter int LEN_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [LEN_W-1:0]   cmd_len,
    output logic               cmd_ready,
    input  logic               st_valid,
    input  logic [STATE_W-1:0] st_in,
    output logic               st_ready,
    output logic               perm_valid,
    output logic [STATE_W-1:0] perm_state,
    input  logic               perm_ready,
    output logic [LANE_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
`ifdef KECCAK_SQUEEZE_ABORT_EN
    input  logic               abort,
`endif
    output logic               done
);
    localparam int LIDX_W = $clog2(RATE_LANES + 1);
    localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(RATE_LANES - 1);

    sq_state_e          r_st;
    logic [STATE_W-1:0] r_state;
    logic [LEN_W-1:0]   r_rem;
    logic [LIDX_W-1:0]  r_lane;
    logic               r_done;
    logic               w_abort;
    logic [LANE_W-1:0]  w_lane;

`ifdef KECCAK_SQUEEZE_ABORT_EN
    assign w_abort = abort && (r_st != SQ_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st    <= SQ_IDLE;
            r_state <= '0;
            r_rem   <= '0;
            r_lane  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_st   <= SQ_IDLE;
                r_done <= 1'b1;
            end else begin
                case (r_st)
                    SQ_IDLE: if (cmd_valid) begin
                        r_rem  <= cmd_len;
                        r_lane <= '0;
                        if (cmd_len == '0) r_done <= 1'b1;
                        else               r_st   <= SQ_WAIT_ST;
                    end
                    SQ_WAIT_ST: if (st_valid) begin
                        r_state <= st_in;
                        r_lane  <= '0;
                        r_st    <= SQ_EMIT;
                    end
                    SQ_EMIT: if (out_ready) begin
                        r_rem <= r_rem - LEN_W'(1);
                        // Command completion wins over the end-of-block wrap.
                        if (r_rem == LEN_W'(1)) begin
                            r_lane <= r_lane + LIDX_W'(1);
                            r_st   <= SQ_IDLE;
                            r_done <= 1'b1;
                        end else if (r_lane == LAST_LANE) begin
                            r_lane <= '0;
                            r_st   <= SQ_PERM;
                        end else begin
                            r_lane <= r_lane + LIDX_W'(1);
                        end
                    end
                    SQ_PERM: if (perm_ready) r_st <= SQ_WAIT_ST;
                    default: r_st <= SQ_IDLE;
                endcase
            end
        end
    end

    keccak_lane_mux u_mux (
        .i_state (r_state),
        .i_idx   (LANE_IDX_W'(r_lane)),
        .o_lane  (w_lane)
    );

    assign cmd_ready  = (r_st == SQ_IDLE);
    assign st_ready   = (r_st == SQ_WAIT_ST);
    assign perm_valid = (r_st == SQ_PERM);
    assign perm_state = r_state;
    assign out_valid  = (r_st == SQ_EMIT);
    assign out_data   = w_lane;
    assign out_last   = out_valid && (r_rem == LEN_W'(1));
    assign done       = r_done;
endmodule
